pkt_mux_rr: RTL

- N-channel packet multiplexer for the local control path. Merges one request/acknowledge source (local report generator) with NUM_CH write-only packet sources (frame encapsulation, frame decapsulation, PTP, ...) onto a single packet bus.
- Each write-only channel has its own show-ahead FIFO with whole-packet admission control.
- Output arbitration: the request channel has strict priority; the FIFO channels are served round-robin, whole packets only.

---
 rtl/pkt_mux_rr.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pkt_mux_rr.sv
// pkt_mux_rr: strict-priority request channel merged with NUM_CH buffered
// channels served round-robin by whole packet. PKT_MUX_DROP_CNT_EN builds drop counters.
module pkt_mux_rr #(
    parameter int DATA_W        = 134,
    parameter int NUM_CH        = 4,
    parameter int FIFO_DEPTH    = 128,
    parameter int MAX_PKT_WORDS = 32,
    parameter int CNT_W         = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_data_req,
    output logic                     o_data_ack,
    input  logic [DATA_W-1:0]        iv_data,
    input  logic [NUM_CH*DATA_W-1:0] iv_ch_data,
    input  logic [NUM_CH-1:0]        iv_ch_wr,
    output logic [DATA_W-1:0]        ov_data,
    output logic                     o_data_wr,
    output logic [NUM_CH*CNT_W-1:0]  ov_drop_cnt
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] MAX_L   = (AW+1)'(MAX_PKT_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT_1CYCLE, TRANS_REQ, TRANS_CH} state_t;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt;
    logic [CH_W-1:0]   nxt_gnt;
    logic              any_elig;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] rd;
    logic [DATA_W-1:0] q [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [DATA_W-1:0] s_data;
        logic              s_vld;
        logic              open;
        logic [AW-1:0]     wp;
        logic [AW-1:0]     rp;
        logic [AW:0]       used;
        logic [AW:0]       pkts;
        logic              s_head;
        logic              s_tail;
        logic              admit;
        logic              wr;
        logic              rd_tail;

        assign s_head  = s_data[DATA_W-2];
        assign s_tail  = s_data[DATA_W-1];
        assign admit   = (DEPTH_L - used) >= MAX_L;
        assign wr      = s_vld && (s_head ? admit : open);
        assign rd[k]   = (state == TRANS_CH) && (gnt == CH_W'(k));
        assign rd_tail = rd[k] && q[k][DATA_W-1];
        assign q[k]    = mem[rp];
        assign elig[k] = (pkts != '0);

        // A refused head leaves open low, so the rest of its packet falls away.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                s_vld  <= 1'b0;
                s_data <= '0;
                open   <= 1'b0;
                wp     <= '0;
                rp     <= '0;
                used   <= '0;
                pkts   <= '0;
            end else begin
                s_vld  <= iv_ch_wr[k];
                s_data <= iv_ch_data[k*DATA_W +: DATA_W];
                if (s_vld)
                    open <= s_head ? (admit && !s_tail) : (open && !s_tail);
                if (wr)
                    wp <= wp + AW'(1);
                if (rd[k])
                    rp <= rp + AW'(1);
                used <= used + (AW+1)'(wr) - (AW+1)'(rd[k]);
                if ((wr && s_tail) != rd_tail)
                    pkts <= rd_tail ? pkts - (AW+1)'(1) : pkts + (AW+1)'(1);
            end
        end

        always_ff @(posedge i_clk) begin
            if (wr)
                mem[wp] <= s_data;
        end

`ifdef PKT_MUX_DROP_CNT_EN
        logic [CNT_W-1:0] drops;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                drops <= '0;
            else if (s_vld && s_head && !admit && drops != '1)
                drops <= drops + CNT_W'(1);
        end

        assign ov_drop_cnt[k*CNT_W +: CNT_W] = drops;
`else
        assign ov_drop_cnt[k*CNT_W +: CNT_W] = '0;
`endif
    end

    // Walk downward so the lowest offset from rr_ptr wins.
    always_comb begin
        int j;
        j        = 0;
        nxt_gnt  = '0;
        any_elig = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_CH)
                j = j - NUM_CH;
            if (elig[CH_W'(j)]) begin
                nxt_gnt  = CH_W'(j);
                any_elig = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            ov_data    <= '0;
            o_data_wr  <= 1'b0;
            o_data_ack <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ov_data   <= '0;
                    o_data_wr <= 1'b0;
                    if (i_data_req) begin
                        o_data_ack <= 1'b1;
                        state      <= WAIT_1CYCLE;
                    end else if (any_elig) begin
                        gnt   <= nxt_gnt;
                        state <= TRANS_CH;
                    end
                end
                WAIT_1CYCLE: begin
                    o_data_ack <= 1'b0;
                    state      <= TRANS_REQ;
                end
                TRANS_REQ: begin
                    ov_data   <= iv_data;
                    o_data_wr <= 1'b1;
                    if (iv_data[DATA_W-1])
                        state <= IDLE;
                end
                TRANS_CH: begin
                    ov_data   <= q[gnt];
                    o_data_wr <= 1'b1;
                    if (q[gnt][DATA_W-1]) begin
                        state  <= IDLE;
                        rr_ptr <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
